// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution window address generator.
package conv_pkg;

  localparam int DIM_W_DEF  = 16;
  localparam int ADDR_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } conv_state_t;

  // Signed input-map coordinate; two extra bits absorb padding and stride overshoot.
  typedef logic signed [DIM_W_DEF+1:0] coord_t;

endpackage

// File: rtl/conv_window_addr_gen_if.sv
// Tap stream from the window address generator to the MAC/line-buffer datapath.
interface conv_window_addr_gen_if #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 20
);

  logic                    win_valid;
  logic                    win_ready;
  logic signed [DIM_W+1:0] win_row;
  logic signed [DIM_W+1:0] win_col;
  logic                    win_pad;
  logic [ADDR_W-1:0]       win_addr;
  logic                    win_first;
  logic                    win_last_tap;
  logic                    win_last;

  modport master (
    output win_valid, win_row, win_col, win_pad, win_addr,
           win_first, win_last_tap, win_last,
    input  win_ready
  );

  modport slave (
    input  win_valid, win_row, win_col, win_pad, win_addr,
           win_first, win_last_tap, win_last,
    output win_ready
  );

endinterface

// File: rtl/conv_tap_counter.sv
// Nested oy/ox/ky/kx counter; each level wraps at its limit when the level below wraps.
module conv_tap_counter
  import conv_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIM_W-1:0] k,
  input  logic [DIM_W-1:0] out_h,
  input  logic [DIM_W-1:0] out_w,
  output logic [DIM_W-1:0] ky,
  output logic [DIM_W-1:0] kx,
  output logic             first,
  output logic             last_tap,
  output logic             ox_last,
  output logic             oy_last,
  output logic             last
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [DIM_W-1:0] oy_q, ox_q, ky_q, kx_q;
  logic             kx_last, ky_last;

  assign kx_last  = (kx_q == k - ONE);
  assign ky_last  = (ky_q == k - ONE);
  assign ox_last  = (ox_q == out_w - ONE);
  assign oy_last  = (oy_q == out_h - ONE);
  assign first    = (kx_q == '0) && (ky_q == '0);
  assign last_tap = kx_last && ky_last;
  assign last     = last_tap && ox_last && oy_last;
  assign ky       = ky_q;
  assign kx       = kx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oy_q <= '0;
      ox_q <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else if (clr) begin
      oy_q <= '0;
      ox_q <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else if (adv) begin
      if (!kx_last) begin
        kx_q <= kx_q + ONE;
      end else begin
        kx_q <= '0;
        if (!ky_last) begin
          ky_q <= ky_q + ONE;
        end else begin
          ky_q <= '0;
          if (!ox_last) begin
            ox_q <= ox_q + ONE;
          end else begin
            ox_q <= '0;
            oy_q <= oy_last ? '0 : oy_q + ONE;
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Walks every output position and kernel tap, emitting one input coordinate per beat.
// Optional CONV_ADDR_PERF_EN adds perf_stall_cnt (saturating stalled-cycle counter).
//
// state | meaning
// IDLE  | waiting for start; geometry latched on start
// RUN   | streaming taps, counters step on each accepted beat
// FIN   | one-cycle done pulse, then back to IDLE
module conv_window_addr_gen
  import conv_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIM_W-1:0] IN_HEIGHT,
  input  logic [DIM_W-1:0] IN_WIDTH,
  input  logic [DIM_W-1:0] KERNEL_SIZE,
  input  logic [DIM_W-1:0] STRIDE,
  input  logic [DIM_W-1:0] PADDING,
  input  logic [DIM_W-1:0] OUT_HEIGHT,
  input  logic [DIM_W-1:0] OUT_WIDTH,
  input  logic             start,
  conv_window_addr_gen_if.master win,
  output logic             busy,
  output logic             done
`ifdef CONV_ADDR_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);

  conv_state_t state_q, state_d;

  logic [DIM_W-1:0] in_h_q, in_w_q, k_q, s_q, p_q, out_h_q, out_w_q;
  logic signed [DIM_W+1:0] base_row_q, base_col_q;
  logic signed [DIM_W+1:0] row, col, neg_p_in, neg_p_q, s_ext;
  logic [DIM_W+1:0]  row_u, col_u;
  logic [ADDR_W-1:0] addr_full;
  logic [DIM_W-1:0]  ky, kx;
  logic first, last_tap, ox_last, oy_last, cnt_last;
  logic start_acc, cnt_adv, degenerate, run, pad;

  assign degenerate = (KERNEL_SIZE == '0) || (OUT_HEIGHT == '0) || (OUT_WIDTH == '0);

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    win.win_valid = 1'b0;
    start_acc     = 1'b0;
    cnt_adv       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = degenerate ? FIN : RUN;
        end
      end
      RUN: begin
        busy          = 1'b1;
        win.win_valid = 1'b1;
        cnt_adv       = win.win_ready;
        if (win.win_ready && cnt_last) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  conv_tap_counter #(.DIM_W(DIM_W)) u_tap_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_acc),
    .adv      (cnt_adv),
    .k        (k_q),
    .out_h    (out_h_q),
    .out_w    (out_w_q),
    .ky       (ky),
    .kx       (kx),
    .first    (first),
    .last_tap (last_tap),
    .ox_last  (ox_last),
    .oy_last  (oy_last),
    .last     (cnt_last)
  );

  assign neg_p_in = -$signed({2'b00, PADDING});
  assign neg_p_q  = -$signed({2'b00, p_q});
  assign s_ext    = $signed({2'b00, s_q});

  // Base coordinates track oy*S-P and ox*S-P by accumulation, so no multiplier is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_h_q     <= '0;
      in_w_q     <= '0;
      k_q        <= '0;
      s_q        <= '0;
      p_q        <= '0;
      out_h_q    <= '0;
      out_w_q    <= '0;
      base_row_q <= '0;
      base_col_q <= '0;
    end else if (start_acc) begin
      in_h_q     <= IN_HEIGHT;
      in_w_q     <= IN_WIDTH;
      k_q        <= KERNEL_SIZE;
      s_q        <= STRIDE;
      p_q        <= PADDING;
      out_h_q    <= OUT_HEIGHT;
      out_w_q    <= OUT_WIDTH;
      base_row_q <= neg_p_in;
      base_col_q <= neg_p_in;
    end else if (cnt_adv && last_tap) begin
      if (ox_last) begin
        base_col_q <= neg_p_q;
        base_row_q <= oy_last ? neg_p_q : base_row_q + s_ext;
      end else begin
        base_col_q <= base_col_q + s_ext;
      end
    end
  end

  assign row   = base_row_q + $signed({2'b00, ky});
  assign col   = base_col_q + $signed({2'b00, kx});
  assign row_u = row;
  assign col_u = col;
  assign pad   = row[DIM_W+1] || (row >= $signed({2'b00, in_h_q})) ||
                 col[DIM_W+1] || (col >= $signed({2'b00, in_w_q}));
  assign addr_full = ADDR_W'(row_u) * ADDR_W'(in_w_q) + ADDR_W'(col_u);

  // Data outputs read as zero outside RUN so reset and idle present a clean bus.
  assign run              = (state_q == RUN);
  assign win.win_row      = run ? row : '0;
  assign win.win_col      = run ? col : '0;
  assign win.win_pad      = run && pad;
  assign win.win_addr     = (run && !pad) ? addr_full : '0;
  assign win.win_first    = run && first;
  assign win.win_last_tap = run && last_tap;
  assign win.win_last     = run && cnt_last;

`ifdef CONV_ADDR_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (start_acc) begin
      perf_stall_cnt <= '0;
    end else if (win.win_valid && !win.win_ready && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: table vectors, random geometry/backpressure vs an index-based model.
module tb_conv_window_addr_gen;
  import conv_pkg::*;

  localparam int DW = 16;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] in_height = '0, in_width = '0, kernel_size = '0, stride = '0;
  logic [DW-1:0] padding = '0, out_height = '0, out_width = '0;
  logic          busy, done;
`ifdef CONV_ADDR_PERF_EN
  logic [31:0]   perf_stall_cnt;
`endif

  conv_window_addr_gen_if #(.DIM_W(DW), .ADDR_W(AW)) win_if();

  conv_window_addr_gen #(.DIM_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IN_HEIGHT   (in_height),
    .IN_WIDTH    (in_width),
    .KERNEL_SIZE (kernel_size),
    .STRIDE      (stride),
    .PADDING     (padding),
    .OUT_HEIGHT  (out_height),
    .OUT_WIDTH   (out_width),
    .start       (start),
    .win         (win_if),
    .busy        (busy),
    .done        (done)
`ifdef CONV_ADDR_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [DW+1:0] row;
    logic signed [DW+1:0] col;
    logic                 pad;
    logic [AW-1:0]        addr;
    logic                 first;
    logic                 last_tap;
    logic                 last;
  } beat_t;

  typedef struct {
    int ih, iw, k, s, p, oh, ow;
    int idx;
    int row, col, pad, addr, first, last_tap, last;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  int g_ih, g_iw, g_k, g_s, g_p, g_oh, g_ow;
  beat_t cap[$];
  int f_seq_errs, f_stall_errs, f_stalls;
  string f_err_msg;

  task automatic check(input string name, input longint act, input longint exp, input string detail = "");
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d %s", name, act, exp, detail);
  endtask

  // Reference: decompose the flat beat index into oy/ox/ky/kx and apply the conv formulas.
  function automatic beat_t model_beat(input int i);
    beat_t b;
    int kk, kx, ky, ox, oy, r, c;
    kk = g_k * g_k;
    kx = i % g_k;
    ky = (i / g_k) % g_k;
    ox = (i / kk) % g_ow;
    oy = i / (kk * g_ow);
    r  = oy * g_s + ky - g_p;
    c  = ox * g_s + kx - g_p;
    b.row      = (DW+2)'(r);
    b.col      = (DW+2)'(c);
    b.pad      = (r < 0) || (r >= g_ih) || (c < 0) || (c >= g_iw);
    b.addr     = b.pad ? '0 : AW'(r * g_iw + c);
    b.first    = (kx == 0) && (ky == 0);
    b.last_tap = (kx == g_k - 1) && (ky == g_k - 1);
    b.last     = (i == g_oh * g_ow * kk - 1);
    return b;
  endfunction

  function automatic beat_t sample();
    beat_t b;
    b.row      = win_if.win_row;
    b.col      = win_if.win_col;
    b.pad      = win_if.win_pad;
    b.addr     = win_if.win_addr;
    b.first    = win_if.win_first;
    b.last_tap = win_if.win_last_tap;
    b.last     = win_if.win_last;
    return b;
  endfunction

  task automatic scramble_geometry();
    in_height   = DW'($urandom);
    in_width    = DW'($urandom);
    kernel_size = DW'($urandom);
    stride      = DW'($urandom);
    padding     = DW'($urandom);
    out_height  = DW'($urandom);
    out_width   = DW'($urandom);
  endtask

  task automatic run_frame(input string tag, input int ih, iw, k, s, p, oh, ow,
                           input bit rnd, input int inj_at, input int abort_at);
    int exp_n, budget, last_iter, done_iter, dones, extra, n;
    bit fin, snap_v;
    beat_t snap, cur, exp_b;
    exp_n = oh * ow * k * k;
    budget = exp_n * 6 + 40;
    last_iter = -1; done_iter = -1; dones = 0; extra = 0;
    fin = 1'b0; snap_v = 1'b0; snap = '0;
    g_ih = ih; g_iw = iw; g_k = k; g_s = s; g_p = p; g_oh = oh; g_ow = ow;
    cap.delete();
    f_seq_errs = 0; f_stall_errs = 0; f_stalls = 0; f_err_msg = "";
    @(negedge clk);
    in_height = DW'(ih); in_width = DW'(iw); kernel_size = DW'(k); stride = DW'(s);
    padding = DW'(p); out_height = DW'(oh); out_width = DW'(ow);
    start = 1'b1;
    win_if.win_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_geometry();
    for (int it = 0; it < budget && !fin; it++) begin
      start = 1'b0;
      if (abort_at >= 0 && cap.size() == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, " rst valid"}, win_if.win_valid, 0);
        check({tag, " rst busy"}, busy, 0);
        check({tag, " rst row"}, win_if.win_row, 0);
        n = 0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          if (done) n++;
        end
        check({tag, " rst no done"}, n, 0);
        rst_n = 1'b1;
        win_if.win_ready = 1'b1;
        return;
      end
      cur = sample();
      if (snap_v && (cur != snap || !win_if.win_valid)) f_stall_errs++;
      snap_v = 1'b0;
      if (done) begin
        dones++;
        if (done_iter < 0) done_iter = it;
        fin = 1'b1;
      end
      if (win_if.win_valid) begin
        win_if.win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (win_if.win_ready) begin
          exp_b = model_beat(cap.size());
          if (cur != exp_b) begin
            f_seq_errs++;
            if (f_err_msg == "")
              f_err_msg = $sformatf("(beat %0d got %h want %h)", cap.size(), cur, exp_b);
          end
          cap.push_back(cur);
          last_iter = it;
        end else begin
          f_stalls++;
          snap = cur;
          snap_v = 1'b1;
        end
        if (inj_at >= 0 && cap.size() == inj_at) start = 1'b1;
      end else begin
        win_if.win_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (done || win_if.win_valid) extra++;
      @(negedge clk);
    end
    win_if.win_ready = 1'b1;
    check({tag, " beats"}, cap.size(), exp_n);
    check({tag, " seq errs"}, f_seq_errs, 0, f_err_msg);
    check({tag, " done count"}, dones, 1);
    check({tag, " done latency"}, done_iter - last_iter, 1);
    check({tag, " idle after"}, extra, 0);
    check({tag, " busy after"}, busy, 0);
    if (rnd) check({tag, " stall stable"}, f_stall_errs, 0);
`ifdef CONV_ADDR_PERF_EN
    check({tag, " perf stalls"}, perf_stall_cnt, f_stalls);
`endif
  endtask

  vec_t vecs[9];

  initial begin
    int pads, vcnt, dpos;
    int ih, iw, k, s, p;
    vec_t v;
    bit need_run;

    vecs[0] = '{4, 4, 3, 1, 1, 4, 4,     0, -1, -1, 1,   0, 1, 0, 0};
    vecs[1] = '{4, 4, 3, 1, 1, 4, 4,     4,  0,  0, 0,   0, 0, 0, 0};
    vecs[2] = '{4, 4, 3, 1, 1, 4, 4,     8,  1,  1, 0,   5, 0, 1, 0};
    vecs[3] = '{4, 4, 3, 1, 1, 4, 4,     9, -1,  0, 1,   0, 1, 0, 0};
    vecs[4] = '{4, 4, 3, 1, 1, 4, 4,   143,  4,  4, 1,   0, 0, 1, 1};
    vecs[5] = '{28, 28, 5, 1, 0, 24, 24, 0,  0,  0, 0,   0, 1, 0, 0};
    vecs[6] = '{28, 28, 5, 1, 0, 24, 24, 14399, 27, 27, 0, 783, 0, 1, 1};
    vecs[7] = '{5, 5, 3, 2, 0, 2, 2,    27,  2,  2, 0,  12, 1, 0, 0};
    vecs[8] = '{5, 5, 3, 2, 0, 2, 2,    35,  4,  4, 0,  24, 0, 1, 1};

    win_if.win_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset valid", win_if.win_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset data", {win_if.win_row, win_if.win_col, win_if.win_pad, win_if.win_addr}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      need_run = (i == 0) || (v.ih != vecs[i-1].ih) || (v.k != vecs[i-1].k) || (v.s != vecs[i-1].s);
      if (need_run) begin
        run_frame($sformatf("tbl%0d", i), v.ih, v.iw, v.k, v.s, v.p, v.oh, v.ow, 1'b0, -1, -1);
        if (v.ih == 28) begin
          pads = 0;
          foreach (cap[j]) if (cap[j].pad) pads++;
          check("28x28 no pad", pads, 0);
        end
      end
      if (cap.size() > v.idx) begin
        check($sformatf("vec%0d row", i), cap[v.idx].row, v.row);
        check($sformatf("vec%0d col", i), cap[v.idx].col, v.col);
        check($sformatf("vec%0d pad", i), cap[v.idx].pad, v.pad);
        check($sformatf("vec%0d addr", i), cap[v.idx].addr, v.addr);
        check($sformatf("vec%0d first", i), cap[v.idx].first, v.first);
        check($sformatf("vec%0d last_tap", i), cap[v.idx].last_tap, v.last_tap);
        check($sformatf("vec%0d last", i), cap[v.idx].last, v.last);
      end else begin
        check($sformatf("vec%0d present", i), cap.size(), v.idx + 1);
      end
    end

    run_frame("bp case1", 4, 4, 3, 1, 1, 4, 4, 1'b1, -1, -1);
    run_frame("start busy", 4, 4, 3, 1, 1, 4, 4, 1'b0, 20, -1);

    for (int r = 0; r < 5; r++) begin
      ih = $urandom_range(1, 7);
      iw = $urandom_range(1, 7);
      k  = $urandom_range(1, 4);
      s  = $urandom_range(1, 3);
      p  = $urandom_range(0, 2);
      if (ih + 2 * p < k || iw + 2 * p < k) p = k;
      run_frame($sformatf("rand%0d", r), ih, iw, k, s, p,
                (ih + 2 * p - k) / s + 1, (iw + 2 * p - k) / s + 1, 1'b1, -1, -1);
    end

    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      in_height = 16'd4; in_width = 16'd4; stride = 16'd1; padding = 16'd0;
      kernel_size = (d == 0) ? 16'd0 : 16'd3;
      out_height  = 16'd2;
      out_width   = (d == 0) ? 16'd2 : 16'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vcnt = 0; dpos = -1;
      for (int j = 0; j < 4; j++) begin
        if (win_if.win_valid) vcnt++;
        if (done && dpos < 0) dpos = j;
        @(negedge clk);
      end
      check($sformatf("degen%0d valid", d), vcnt, 0);
      check($sformatf("degen%0d done in 2", d), (dpos >= 0) && (dpos <= 1), 1);
    end

    run_frame("abort50", 4, 4, 3, 1, 1, 4, 4, 1'b0, -1, 50);
    run_frame("replay", 4, 4, 3, 1, 1, 4, 4, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
